// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel runs its own ratio/mode,
// with reconfiguration shadowed and applied only at a period boundary.
module clock_divider_multi #(
    parameter int CHANNELS      = 4,
    parameter int WIDTH         = 16,
    parameter int DEFAULT_RATIO = 10,
    parameter int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_ratio,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic                run_q   [CHANNELS];
    logic                run_d   [CHANNELS];
    logic [WIDTH-1:0]    cnt_q   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d   [CHANNELS];
    logic [WIDTH-1:0]    ratio_q [CHANNELS];
    logic [WIDTH-1:0]    ratio_d [CHANNELS];
    logic                mode_q  [CHANNELS];
    logic                mode_d  [CHANNELS];
    logic [WIDTH-1:0]    shr_q   [CHANNELS];
    logic [WIDTH-1:0]    shr_d   [CHANNELS];
    logic                shm_q   [CHANNELS];
    logic                shm_d   [CHANNELS];
    logic                pend_q  [CHANNELS];
    logic                pend_d  [CHANNELS];
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;

    // Square mode needs at least two cycles per period; pulse mode at least one.
    function automatic logic [WIDTH-1:0] eff_ratio(input logic [WIDTH-1:0] r, input logic m);
        logic [WIDTH-1:0] e;
        if (m) begin
            e = (r < WIDTH'(1)) ? WIDTH'(1) : r;
        end else begin
            e = (r < WIDTH'(2)) ? WIDTH'(2) : r;
        end
        return e;
    endfunction

    function automatic logic wave(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] e,
                                  input logic m);
        logic w;
        if (m) begin
            w = (k == e - WIDTH'(1));
        end else begin
            w = (k >= (e >> 1));
        end
        return w;
    endfunction

    // Per-channel next state; the outputs are derived from the next-state count.
    always_comb begin
        logic bnd;
        logic wr;
        clk_out_d = {CHANNELS{1'b0}};
        tick_d    = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            bnd        = 1'b0;
            wr         = cfg_we && (cfg_ch == CH_W'(c));
            run_d[c]   = run_q[c];
            cnt_d[c]   = cnt_q[c];
            if (!enable[c] || (ratio_q[c] == WIDTH'(0))) begin
                run_d[c] = 1'b0;
                cnt_d[c] = WIDTH'(0);
                bnd      = 1'b1;
            end else if (!run_q[c] || sync ||
                         (cnt_q[c] == eff_ratio(ratio_q[c], mode_q[c]) - WIDTH'(1))) begin
                run_d[c] = 1'b1;
                cnt_d[c] = WIDTH'(0);
                bnd      = 1'b1;
            end else begin
                cnt_d[c] = cnt_q[c] + WIDTH'(1);
            end
            // Only a value already pending moves to active; this edge's write waits.
            if (bnd && pend_q[c]) begin
                ratio_d[c] = shr_q[c];
                mode_d[c]  = shm_q[c];
                pend_d[c]  = 1'b0;
            end else begin
                ratio_d[c] = ratio_q[c];
                mode_d[c]  = mode_q[c];
                pend_d[c]  = pend_q[c];
            end
            if (wr) begin
                shr_d[c]  = cfg_ratio;
                shm_d[c]  = cfg_mode;
                pend_d[c] = 1'b1;
            end else begin
                shr_d[c] = shr_q[c];
                shm_d[c] = shm_q[c];
            end
            clk_out_d[c] = run_d[c] &
                           wave(cnt_d[c], eff_ratio(ratio_d[c], mode_d[c]), mode_d[c]);
            tick_d[c]    = run_d[c] & (cnt_d[c] == WIDTH'(0));
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                run_q[c]   <= 1'b0;
                cnt_q[c]   <= WIDTH'(0);
                ratio_q[c] <= WIDTH'(DEFAULT_RATIO);
                mode_q[c]  <= 1'b0;
                shr_q[c]   <= WIDTH'(DEFAULT_RATIO);
                shm_q[c]   <= 1'b0;
                pend_q[c]  <= 1'b0;
            end
            clk_out_q <= {CHANNELS{1'b0}};
            tick_q    <= {CHANNELS{1'b0}};
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                run_q[c]   <= run_d[c];
                cnt_q[c]   <= cnt_d[c];
                ratio_q[c] <= ratio_d[c];
                mode_q[c]  <= mode_d[c];
                shr_q[c]   <= shr_d[c];
                shm_q[c]   <= shm_d[c];
                pend_q[c]  <= pend_d[c];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: directed scenarios plus random traffic, checked every
// cycle against a timestamp-based model of each channel's period.
module tb_clock_divider_multi;
    localparam int NCH = 5;
    localparam int W   = 16;
    localparam int DEF = 10;
    localparam int CW  = 3;

    logic           clk_in = 1'b0;
    logic           reset = 1'b0, sync = 1'b0, cfg_we = 1'b0, cfg_mode = 1'b0;
    logic [NCH-1:0] enable = '0;
    logic [CW-1:0]  cfg_ch = '0;
    logic [W-1:0]   cfg_ratio = '0;
    logic [NCH-1:0] clk_out, tick;

    int total = 0;
    int bad   = 0;

    clock_divider_multi #(.CHANNELS(NCH), .WIDTH(W), .DEFAULT_RATIO(DEF)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .sync(sync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_ratio(cfg_ratio), .cfg_mode(cfg_mode),
        .clk_out(clk_out), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    // Model: each channel remembers the edge number its current period began on.
    int             edge_n = 0;
    bit             chk_en = 1'b0;
    bit             m_run  [NCH];
    int             m_start[NCH];
    int             m_r    [NCH];
    bit             m_m    [NCH];
    int             m_sr   [NCH];
    bit             m_sm   [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] exp_clk = '0, exp_tick = '0;

    function automatic int eff(int r, bit m);
        if (m) return (r < 1) ? 1 : r;
        return (r < 2) ? 2 : r;
    endfunction

    always @(posedge clk_in) begin
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            if (reset) begin
                m_run[c] = 0; m_start[c] = edge_n; m_r[c] = DEF; m_m[c] = 0;
                m_sr[c] = DEF; m_sm[c] = 0; m_pend[c] = 0;
            end else begin
                bit bnd;
                bnd = 0;
                if (!enable[c] || m_r[c] == 0) begin
                    m_run[c] = 0; bnd = 1;
                end else if (!m_run[c] || sync || (edge_n - m_start[c] == eff(m_r[c], m_m[c]))) begin
                    m_run[c] = 1; m_start[c] = edge_n; bnd = 1;
                end
                if (bnd && m_pend[c]) begin
                    m_r[c] = m_sr[c]; m_m[c] = m_sm[c]; m_pend[c] = 0;
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_sr[c] = int'(cfg_ratio); m_sm[c] = cfg_mode; m_pend[c] = 1;
                end
            end
            begin
                int k, e;
                k = edge_n - m_start[c];
                e = eff(m_r[c], m_m[c]);
                exp_tick[c] = m_run[c] && (k == 0);
                exp_clk[c]  = m_run[c] && (m_m[c] ? (k == e - 1) : (k >= e / 2));
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            check("model_clk_out", 32'(clk_out), 32'(exp_clk));
            check("model_tick", 32'(tick), 32'(exp_tick));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic cfg_write(int ch, int r, bit m);
        cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_ratio = W'(r); cfg_mode = m;
        @(negedge clk_in);
        cfg_we = 1'b0;
    endtask

    task automatic wait_tick(int ch, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (!tick[ch] && n < 200);
    endtask

    initial begin
        logic [19:0] cap_c, cap_t, mod_c, mod_t;
        logic [13:0] c1, c2, t2, o4;
        int          n;

        reset = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        check("rst_clk_out", 32'(clk_out), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);

        // Default ratio 10 square on channel 0, first tick right after enable.
        reset = 1'b0; enable[0] = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk_in);
            cap_c[j] = clk_out[0]; cap_t[j] = tick[0];
            mod_c[j] = exp_clk[0]; mod_t[j] = exp_tick[0];
        end
        check("def_clk", 32'(cap_c), 32'(20'b11111_00000_11111_00000));
        check("def_tick", 32'(cap_t), 32'(20'b00000_00001_00000_00001));
        check("model_def_clk", 32'(mod_c), 32'(20'b11111_00000_11111_00000));
        check("model_def_tick", 32'(mod_t), 32'(20'b00000_00001_00000_00001));

        // Mid-period write completes the current period; write on wrap edge waits one.
        cyc(4);
        cfg_write(0, 4, 1'b0);
        wait_tick(0, n); check("midwr_rest", 32'(n), 32'd6);
        wait_tick(0, n); check("midwr_new1", 32'(n), 32'd4);
        wait_tick(0, n); check("midwr_new2", 32'(n), 32'd4);
        cyc(3);
        cfg_write(0, 6, 1'b0);
        wait_tick(0, n); check("wrapwr_old", 32'(n), 32'd4);
        wait_tick(0, n); check("wrapwr_new", 32'(n), 32'd6);

        // R=7 square, R=1 pulse, R=0 held low.
        enable = '0; cyc(1);
        cfg_write(1, 7, 1'b0); cfg_write(2, 1, 1'b1); cfg_write(4, 0, 1'b0); cyc(1);
        enable = 5'b10110;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk_in);
            c1[j] = clk_out[1]; c2[j] = clk_out[2]; t2[j] = tick[2];
            o4[j] = clk_out[4] | tick[4];
        end
        check("r7_clk", 32'(c1), 32'(14'b1111000_1111000));
        check("r1_clk", 32'(c2), 32'h3fff);
        check("r1_tick", 32'(t2), 32'h3fff);
        check("r0_idle", 32'(o4), 32'h0);

        // Skewed channels realigned by sync.
        enable = '0; cyc(1);
        cfg_write(0, 3, 1'b0); cfg_write(1, 4, 1'b0); cfg_write(2, 5, 1'b0);
        cfg_write(3, 6, 1'b0); cyc(1);
        enable[0] = 1'b1; cyc(1); enable[1] = 1'b1; cyc(2);
        enable[2] = 1'b1; cyc(3); enable[3] = 1'b1; cyc(7);
        sync = 1'b1; @(negedge clk_in); sync = 1'b0;
        check("sync_tick", 32'(tick), 32'(5'b01111));
        cyc(20);

        // Enable drop mid-period and clean restart.
        enable = '0; cfg_write(0, 10, 1'b0); cyc(1);
        enable = 5'b00001;
        wait_tick(0, n); check("en_latency", 32'(n), 32'd1);
        cyc(6); check("drop_pre_clk", 32'(clk_out[0]), 32'd1);
        enable[0] = 1'b0; @(negedge clk_in);
        check("drop_clk", 32'(clk_out[0]), 32'd0);
        check("drop_tick", 32'(tick[0]), 32'd0);
        cyc(2); enable[0] = 1'b1; @(negedge clk_in);
        check("reen_tick", 32'(tick[0]), 32'd1);
        cyc(4); check("reen_low", 32'(clk_out[0]), 32'd0);
        cyc(1); check("reen_high", 32'(clk_out[0]), 32'd1);

        // Reset discards pending write; out-of-range channel write ignored.
        cfg_write(0, 3, 1'b0);
        reset = 1'b1; @(negedge clk_in);
        check("rst2_clk", 32'(clk_out), 32'h0);
        check("rst2_tick", 32'(tick), 32'h0);
        reset = 1'b0;
        wait_tick(0, n); check("rst2_start", 32'(n), 32'd1);
        cfg_write(5, 2, 1'b1);
        wait_tick(0, n);
        wait_tick(0, n); check("rst2_period", 32'(n), 32'd10);

        // Random traffic against the model.
        enable = '1;
        for (int i = 0; i < 3000; i++) begin
            int idx;
            reset = ($urandom_range(0, 499) == 0);
            sync  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) begin
                idx = $urandom_range(0, NCH - 1);
                enable[idx] = ~enable[idx];
            end
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_ch    = CW'($urandom_range(0, 7));
            cfg_ratio = W'($urandom_range(0, 12));
            cfg_mode  = 1'($urandom_range(0, 1));
            @(negedge clk_in);
        end
        reset = 1'b0; sync = 1'b0; cfg_we = 1'b0;
        cyc(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Multi-channel programmable clock divider. It generates CHANNELS independent divided-clock enables/waveforms from one input clock. Each channel has a runtime-writable ratio and a mode (square or single-cycle pulse), applied glitch-free at its period boundary. A global sync restarts all channels phase-aligned. It serves peripheral timing (baud, scan, PWM base), replacing per-instance fixed single dividers.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 16, ratio/counter width in bits
- DEFAULT_RATIO, 10, ratio loaded into every channel at reset (must fit WIDTH)
- CH_W, $clog2(CHANNELS) (min 1), width of channel select
- clk_in  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high; overrides everything
- enable  input  CHANNELS  per-channel run enable
- sync  input  1  restart all running channels at period start
- cfg_we  input  1  config write strobe, one write per asserted cycle
- cfg_ch  input  CH_W  channel addressed by write
- cfg_ratio  input  WIDTH  new ratio R
- cfg_mode  input  1  0 = square, 1 = pulse
- clk_out  output  CHANNELS  registered divided output per channel
- tick  output  CHANNELS  registered one-cycle strobe, high in first cycle of each period

## Operation
- Per channel state: run flag, counter cnt (WIDTH), active R/mode, shadow R/mode, pending flag.
- Effective ratio E: square mode E = max(R,2); pulse mode E = max(R,1); R = 0 → channel held idle (as if enable low).
- Waveform: during a cycle in which cnt = k (run high): square clk_out = (k >= floor(E/2)), i.e. low floor(E/2) cycles then high E−floor(E/2); pulse clk_out = (k == E−1). tick = (k == 0).
- Outputs are registered: clk_out/tick computed from next-state cnt, never combinational from inputs.
- Idle (run = 0): cnt = 0, clk_out = 0, tick = 0.
- Edge priority per channel: reset > enable low / R = 0 > sync > wrap > count.
  - enable low: run ← 0, cnt ← 0, clk_out ← 0, tick ← 0; pending shadow applied immediately.
  - enable high while idle: run ← 1, cnt ← 0 (first period starts; tick ← 1).
  - sync high while running: cnt ← 0, pending applied, tick ← 1, clk_out ← f(0).
  - cnt = E−1: cnt ← 0 (wrap), pending applied; new period uses new E/mode.
  - otherwise cnt ← cnt+1.
- Config write: cfg_we with cfg_ch < CHANNELS loads shadow, sets pending; cfg_ch ≥ CHANNELS ignored. Multiple writes before boundary: last wins.
- Write on the same edge as a wrap/sync is not applied at that boundary; it becomes pending for the next one (any earlier pending value is applied at this boundary).
- Active R never changes mid-period: no runt or stretched pulses except via enable low or sync.

## Timing
- Reset (sampled on an edge): all channels run = 0, cnt = 0, R = DEFAULT_RATIO, mode = 0, pending = 0, clk_out = 0, tick = 0.
- Enable rise latency: enable sampled high at edge n → tick high in cycle n+1 (cnt = 0).
- Enable fall: clk_out/tick low from the cycle after the edge sampling enable low.
- Period exactly E clk_in cycles; tick and square rising edge separated by floor(E/2) cycles.
- Idle-channel config write takes effect at the next edge; running-channel write at next wrap/sync.
- Counter arithmetic modulo 2^WIDTH never reached (wrap at E−1 ≤ 2^WIDTH−1).

## Test plan
- Reset, enable[0]=1, default R=10 square → tick every 10 cycles, clk_out low 5 / high 5, first tick one cycle after enable.
- R=7 square on ch1 → low 3, high 4, period 7; R=1 pulse on ch2 → clk_out and tick constant 1; R=0 → ch held low.
- Ch0 running R=10, write R=4 at cnt=3 → current period completes 10 cycles, next periods 4; write on wrap edge → applied one period later.
- Channels 0..3 with R=3,4,5,6 running skewed, pulse sync → all tick in the following cycle, then periods resume independently.
- Drop enable mid-period (cnt=6, clk_out high) → clk_out 0 next cycle; re-enable → fresh period from cnt=0, no runt pulse.
- Assert reset mid-operation with pending write → all outputs 0 next cycle, R back to 10, pending discarded; cfg_ch=5 with CHANNELS=4 → no channel changes.
